// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the divide-by-zero quotient constant.
package div_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [WIDTH_DEF-1:0] QUOT_DBZ = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, try to subtract the divisor, keep the difference if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // One guard bit above the partial remainder so a negative trial shows in the MSB.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[WIDTH+1];
        rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_div16.sv
// Sequential unsigned divider, one quotient bit per clock, start/busy/done handshake.
// Optional SEQ_DIV_EARLY_EXIT_EN: dividend < divisor finishes immediately.
module seq_div16
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH);

    // Handshake: start is taken only in IDLE; busy marks RUN; done is a
    // one-cycle pulse in DONE while quotient/remainder/div_by_zero are valid.
    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             zero_div;
    logic             early_exit;
    logic [WIDTH:0]   step_rem;
    logic             step_bit;

    assign accept   = (state_q == IDLE) && start;
    assign zero_div = (divisor == '0);
`ifdef SEQ_DIV_EARLY_EXIT_EN
    assign early_exit = !zero_div && (dividend < divisor);
`else
    assign early_exit = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (zero_div || early_exit) ? DONE : RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        state_dbg = state_q;
    end

    always_comb begin
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (accept) begin
            cnt_d       = CNT_W'(WIDTH - 1);
            prem_d      = '0;
            dvd_d       = dividend;
            dsr_d       = divisor;
            quotient_d  = '0;
            remainder_d = '0;
            dbz_d       = 1'b0;
            if (zero_div) begin
                quotient_d  = QUOT_DBZ;
                remainder_d = dividend;
                dbz_d       = 1'b1;
            end else if (early_exit) begin
                remainder_d = dividend;
            end
        end else if (state_q == RUN) begin
            // The dividend register fills with quotient bits from the LSB as it drains.
            cnt_d  = cnt_q - CNT_W'(1);
            prem_d = step_rem;
            dvd_d  = {dvd_q[WIDTH-2:0], step_bit};
            if (cnt_q == '0) begin
                quotient_d  = {dvd_q[WIDTH-2:0], step_bit};
                remainder_d = step_rem[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            prem_q      <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div16.sv
// Directed bench for seq_div16: latency, handshake, divide-by-zero, ignored starts, reset abort.
module tb_seq_div16;

    localparam int W = 16;
`ifdef SEQ_DIV_EARLY_EXIT_EN
    localparam int EE_LAT  = 1;
    localparam int EE_BUSY = 0;
`else
    localparam int EE_LAT  = 17;
    localparam int EE_BUSY = 16;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    seq_div16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one start pulse; returns just after the accepting edge. Operand
    // inputs are scrambled afterwards to show they are not re-sampled.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom_range(0, 65535));
        divisor  = W'($urandom_range(0, 65535));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input int elat, input int ebusy);
        int lat;
        int bc;
        bit seen;
        lat  = 0;
        bc   = 0;
        seen = 0;
        launch(a, b);
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !done) begin
                check({tag, "_clr_q"}, quotient, 0);
                check({tag, "_clr_r"}, remainder, 0);
                check({tag, "_clr_z"}, div_by_zero, 0);
            end
            if (busy) bc++;
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_cycles"}, bc, ebusy);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, state_dbg, 0);
        check({tag, "_hold_q"}, quotient, eq);
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        bit seen;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_z", div_by_zero, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;

        run_op("d1000_7",   16'd1000, 16'd7,    16'd142,  16'd6,    1'b0, 17, 16);
        run_op("dffff_1",   16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17, 16);
        run_op("dffff_ffff",16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17, 16);
        run_op("d5_0",      16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1, 1,  0);
        run_op("dabcd_100", 16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0, 17, 16);
        run_op("d3_10",     16'd3,    16'd10,   16'd0,    16'd3,    1'b0, EE_LAT, EE_BUSY);

        // A start pulsed mid-run must be ignored.
        launch(16'd1000, 16'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 5;
        seen  = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1;
        end
        check("ign_done_seen", seen, 1);
        check("ign_latency", lat, 17);
        check("ign_quotient", quotient, 142);
        check("ign_remainder", remainder, 6);
        count_done(25, pulses);
        check("ign_extra_done", pulses, 0);

        // Reset mid-run discards the operation.
        launch(16'd1000, 16'd7);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_z", div_by_zero, 0);
        check("abort_state", state_dbg, 0);
        rst = 1'b0;
        count_done(25, pulses);
        check("abort_no_done", pulses, 0);
        run_op("d9_2", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 17, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
